// File: rtl/cruise_speed_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cruise_speed_ctrl_pkg
// Shared definitions for the cruise speed controller: state codes (also used by
// the display/decoder stage), default pulse dividers and a helper that selects
// the divider for the current state.
// Optional feature macro used by the controller: CRUISE_RESUME_EN.
// -----------------------------------------------------------------------------
package cruise_speed_ctrl_pkg;

    localparam int SPEED_W_DEF    = 7;
    localparam int MAX_SPEED_DEF  = 100;
    localparam int MIN_CRUISE_DEF = 40;
    localparam int ACCEL_DIV_DEF  = 4;
    localparam int BRAKE_DIV_DEF  = 2;
    localparam int COAST_DIV_DEF  = 16;

    // Wide enough for any divider up to 31.
    localparam int TICK_W = 5;

    typedef enum logic [2:0] {
        CS_IDLE   = 3'd0,
        CS_ACCEL  = 3'd1,
        CS_DECEL  = 3'd2,
        CS_CRUISE = 3'd3,
        CS_BRAKE  = 3'd4
    } cs_state_e;

    // Pulse spacing for a given state; ACCEL, DECEL and CRUISE share one rate.
    function automatic logic [TICK_W-1:0] div_for_state(
        input cs_state_e st,
        input int        accel_div,
        input int        brake_div,
        input int        coast_div
    );
        logic [TICK_W-1:0] d;
        case (st)
            CS_ACCEL, CS_DECEL, CS_CRUISE: d = TICK_W'(accel_div);
            CS_BRAKE:                      d = TICK_W'(brake_div);
            CS_IDLE:                       d = TICK_W'(coast_div);
            default:                       d = TICK_W'(coast_div);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cruise_speed_ctrl_rate_ticker.sv
// -----------------------------------------------------------------------------
// rate_ticker
// Loadable modulo counter. Counts 0..div_i-1 and flags the cycle in which it
// wraps; restart_i forces the count back to 0 and suppresses the flag.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   div_i      modulus (must be >= 2)
//   restart_i  synchronous restart (state change in the controller)
//   tick_o     high while the count is at div_i-1 and no restart is requested
// -----------------------------------------------------------------------------
module rate_ticker
    import cruise_speed_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TICK_W-1:0] div_i,
    input  logic              restart_i,
    output logic              tick_o
);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;
    logic              wrap_s;

    assign wrap_s = (count_q == (div_i - TICK_W'(1)));
    assign tick_o = wrap_s & ~restart_i;

    // Next count: restart or wrap return to zero, otherwise advance.
    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = {TICK_W{1'b0}};
        end else if (wrap_s) begin
            count_d = {TICK_W{1'b0}};
        end else begin
            count_d = count_q + TICK_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {TICK_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cruise_speed_ctrl.sv
// -----------------------------------------------------------------------------
// cruise_speed_ctrl
// Control FSM in front of the speed counter. Converts driver commands into
// one-cycle enable pulses with a direction (mode) for the counter, and holds a
// cruise target that the speed is steered towards while cruising.
// Optional feature macro: CRUISE_RESUME_EN (adds 'resume', keeps the target
// across brake/cancel so cruise can be re-engaged from IDLE).
// Ports:
//   clk, clear                  clock / asynchronous active-low reset
//   speed                       current speed from the counter
//   brake, cancel, accelerate,
//   decelerate, set_cruise      driver command levels (brake highest priority)
//   resume                      only with CRUISE_RESUME_EN
//   cnt_enable, cnt_mode        counter pulse and direction (1 = up)
//   cruise_on                   high while in CRUISE
//   target_speed                latched cruise target
//   state                       current state code
// -----------------------------------------------------------------------------
module cruise_speed_ctrl
    import cruise_speed_ctrl_pkg::*;
#(
    parameter int SPEED_W    = SPEED_W_DEF,
    parameter int MAX_SPEED  = MAX_SPEED_DEF,
    parameter int MIN_CRUISE = MIN_CRUISE_DEF,
    parameter int ACCEL_DIV  = ACCEL_DIV_DEF,
    parameter int BRAKE_DIV  = BRAKE_DIV_DEF,
    parameter int COAST_DIV  = COAST_DIV_DEF
)(
    input  logic               clk,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    input  logic               brake,
    input  logic               cancel,
    input  logic               accelerate,
    input  logic               decelerate,
    input  logic               set_cruise,
`ifdef CRUISE_RESUME_EN
    input  logic               resume,
`endif
    output logic               cnt_enable,
    output logic               cnt_mode,
    output logic               cruise_on,
    output logic [SPEED_W-1:0] target_speed,
    output logic [2:0]         state
);

    localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] MIN_S = SPEED_W'(MIN_CRUISE);

    cs_state_e          state_q;
    cs_state_e          state_d;
    logic               set_take_s;
    logic               tick_s;
    logic               pulse_ok_s;
    logic               pulse_up_s;
    logic               enable_q;
    logic               mode_q;
    logic               cruise_q;
    logic [SPEED_W-1:0] target_q;

    assign cnt_enable   = enable_q;
    assign cnt_mode     = mode_q;
    assign cruise_on    = cruise_q;
    assign target_speed = target_q;
    assign state        = state_q;

    // Any state change restarts the pulse spacing from zero.
    rate_ticker u_ticker (
        .clk       (clk),
        .rst_n     (clear),
        .div_i     (div_for_state(state_q, ACCEL_DIV, BRAKE_DIV, COAST_DIV)),
        .restart_i (state_d != state_q),
        .tick_o    (tick_s)
    );

    // Command priority decode; set_take_s marks an accepted set_cruise.
    always_comb begin
        state_d    = state_q;
        set_take_s = 1'b0;
        if (brake) begin
            state_d = CS_BRAKE;
        end else if (cancel) begin
            state_d = CS_IDLE;
        end else if (accelerate && !decelerate) begin
            state_d = CS_ACCEL;
        end else if (decelerate && !accelerate) begin
            state_d = CS_DECEL;
        end else if (set_cruise && (speed >= MIN_S)) begin
            state_d    = CS_CRUISE;
            set_take_s = 1'b1;
`ifdef CRUISE_RESUME_EN
        end else if (resume && (state_q == CS_IDLE) && (target_q >= MIN_S)) begin
            state_d = CS_CRUISE;
`endif
        end else begin
            case (state_q)
                CS_CRUISE: state_d = CS_CRUISE;
                CS_ACCEL,
                CS_DECEL,
                CS_BRAKE,
                CS_IDLE:   state_d = CS_IDLE;
                default:   state_d = CS_IDLE;
            endcase
        end
    end

    // Whether a pulse may be issued now, and in which direction.
    always_comb begin
        pulse_ok_s = 1'b0;
        pulse_up_s = 1'b0;
        case (state_q)
            CS_ACCEL: begin
                pulse_ok_s = (speed < MAX_S);
                pulse_up_s = 1'b1;
            end
            CS_DECEL, CS_BRAKE, CS_IDLE: begin
                pulse_ok_s = (speed != {SPEED_W{1'b0}});
                pulse_up_s = 1'b0;
            end
            CS_CRUISE: begin
                if (speed < target_q) begin
                    pulse_ok_s = 1'b1;
                    pulse_up_s = 1'b1;
                end else if (speed > target_q) begin
                    pulse_ok_s = 1'b1;
                    pulse_up_s = 1'b0;
                end else begin
                    pulse_ok_s = 1'b0;
                    pulse_up_s = 1'b0;
                end
            end
            default: begin
                pulse_ok_s = 1'b0;
                pulse_up_s = 1'b0;
            end
        endcase
    end

    // FSM state, registered pulse outputs and cruise target.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q  <= CS_IDLE;
            enable_q <= 1'b0;
            mode_q   <= 1'b0;
            cruise_q <= 1'b0;
            target_q <= {SPEED_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cruise_q <= (state_d == CS_CRUISE);
            // Mode rests at 0 so the counter never sees a stale direction.
            if (tick_s && pulse_ok_s) begin
                enable_q <= 1'b1;
                mode_q   <= pulse_up_s;
            end else begin
                enable_q <= 1'b0;
                mode_q   <= 1'b0;
            end
            if (set_take_s) begin
                target_q <= speed;
`ifndef CRUISE_RESUME_EN
            end else if ((state_q == CS_CRUISE) && (state_d != CS_CRUISE)) begin
                target_q <= {SPEED_W{1'b0}};
`endif
            end else begin
                target_q <= target_q;
            end
        end
    end

endmodule

// File: tb/tb_cruise_speed_ctrl.sv
module tb_cruise_speed_ctrl;

    logic       clk   = 1'b0;
    logic       clear = 1'b1;
    logic [6:0] speed = 7'd0;
    logic       brake = 1'b0;
    logic       cancel = 1'b0;
    logic       accelerate = 1'b0;
    logic       decelerate = 1'b0;
    logic       set_cruise = 1'b0;
`ifdef CRUISE_RESUME_EN
    logic       resume = 1'b0;
`endif
    logic       cnt_enable;
    logic       cnt_mode;
    logic       cruise_on;
    logic [6:0] target_speed;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit follow = 1'b0;
    bit seen;

    cruise_speed_ctrl dut (
        .clk          (clk),
        .clear        (clear),
        .speed        (speed),
        .brake        (brake),
        .cancel       (cancel),
        .accelerate   (accelerate),
        .decelerate   (decelerate),
        .set_cruise   (set_cruise),
`ifdef CRUISE_RESUME_EN
        .resume       (resume),
`endif
        .cnt_enable   (cnt_enable),
        .cnt_mode     (cnt_mode),
        .cruise_on    (cruise_on),
        .target_speed (target_speed),
        .state        (state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // State numbers: 0 IDLE, 1 ACCEL, 2 DECEL, 3 CRUISE, 4 BRAKE.
    // m_age = edges since the state was entered; a pulse is due whenever the
    // age is a non-zero multiple of that state's divider.
    int         m_state = 0;
    int         m_age   = 0;
    logic [6:0] m_target = 7'd0;
    bit         m_en = 1'b0;
    bit         m_mode = 1'b0;

    int         n_state;
    int         n_age;
    logic [6:0] n_target;
    bit         n_en;
    bit         n_mode;
    bit         allow;
    bit         up;

    function automatic int div_of(input int st);
        case (st)
            1, 2, 3: return 4;
            4:       return 2;
            default: return 16;
        endcase
    endfunction

    always_comb begin
        n_state  = m_state;
        n_target = m_target;
        allow    = 1'b0;
        up       = 1'b0;
        if (brake) n_state = 4;
        else if (cancel) n_state = 0;
        else if (accelerate && !decelerate) n_state = 1;
        else if (decelerate && !accelerate) n_state = 2;
        else if (set_cruise && speed >= 7'd40) begin
            n_state  = 3;
            n_target = speed;
        end
`ifdef CRUISE_RESUME_EN
        else if (resume && m_state == 0 && m_target >= 7'd40) n_state = 3;
`endif
        else n_state = (m_state == 3) ? 3 : 0;
`ifndef CRUISE_RESUME_EN
        if (m_state == 3 && n_state != 3) n_target = 7'd0;
`endif
        n_age = (n_state == m_state) ? m_age + 1 : 0;
        case (m_state)
            1: begin allow = (speed < 7'd100); up = 1'b1; end
            3: begin allow = (speed != m_target); up = (speed < m_target); end
            default: begin allow = (speed != 7'd0); up = 1'b0; end
        endcase
        n_en   = (n_state == m_state) && ((n_age % div_of(m_state)) == 0) && allow;
        n_mode = n_en && up;
    end

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            m_state  <= 0;
            m_age    <= 0;
            m_target <= 7'd0;
            m_en     <= 1'b0;
            m_mode   <= 1'b0;
        end else begin
            m_state  <= n_state;
            m_age    <= n_age;
            m_target <= n_target;
            m_en     <= n_en;
            m_mode   <= n_mode;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (clear) begin
            chk("cnt_enable", int'(cnt_enable), int'(m_en));
            chk("cnt_mode", int'(cnt_mode), int'(m_mode));
            chk("cruise_on", int'(cruise_on), int'(m_state == 3));
            chk("target_speed", int'(target_speed), int'(m_target));
            chk("state", int'(state), m_state);
        end
    end

    // Advance n cycles; optionally let speed follow the pulses like the counter.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cnt_enable) begin
                pulses++;
                if (follow) speed = cnt_mode ? speed + 7'd1 : speed - 7'd1;
            end
        end
    endtask

    initial begin
        #1 clear = 1'b0;
        #2;
        chk("rst_enable", int'(cnt_enable), 0);
        chk("rst_mode", int'(cnt_mode), 0);
        chk("rst_cruise", int'(cruise_on), 0);
        chk("rst_target", int'(target_speed), 0);
        chk("rst_state", int'(state), 0);
        cyc(2);
        clear = 1'b1;

        // 1: accelerate from 0, pulse every 4 cycles after entry
        speed = 7'd0;
        accelerate = 1'b1;
        pulses = 0;
        cyc(1);
        chk("t1_state", int'(state), 1);
        cyc(3);
        chk("t1_no_early", int'(cnt_enable), 0);
        cyc(1);
        chk("t1_first_en", int'(cnt_enable), 1);
        chk("t1_first_mode", int'(cnt_mode), 1);
        cyc(15);
        chk("t1_pulses", pulses, 4);

        // 2: at MAX no up pulses; decelerate to 0 then stop
        speed = 7'd100;
        pulses = 0;
        cyc(12);
        chk("t2_max_pulses", pulses, 0);
        accelerate = 1'b0;
        decelerate = 1'b1;
        speed = 7'd2;
        follow = 1'b1;
        pulses = 0;
        cyc(20);
        chk("t2_dec_pulses", pulses, 2);
        chk("t2_speed", int'(speed), 0);
        follow = 1'b0;

        // 3: engage cruise at 50, converge from 47, re-latch at 55
        decelerate = 1'b0;
        speed = 7'd50;
        set_cruise = 1'b1;
        cyc(1);
        chk("t3_state", int'(state), 3);
        chk("t3_cruise_on", int'(cruise_on), 1);
        chk("t3_target", int'(target_speed), 50);
        set_cruise = 1'b0;
        speed = 7'd47;
        follow = 1'b1;
        pulses = 0;
        cyc(24);
        chk("t3_up_pulses", pulses, 3);
        chk("t3_speed", int'(speed), 50);
        follow = 1'b0;
        speed = 7'd55;
        set_cruise = 1'b1;
        cyc(1);
        chk("t3_relatch", int'(target_speed), 55);
        set_cruise = 1'b0;

        // 4: brake with accelerate wins; down pulses every 2 cycles
        brake = 1'b1;
        accelerate = 1'b1;
        cyc(1);
        chk("t4_state", int'(state), 4);
        chk("t4_cruise_on", int'(cruise_on), 0);
`ifdef CRUISE_RESUME_EN
        chk("t4_target", int'(target_speed), 55);
`else
        chk("t4_target", int'(target_speed), 0);
`endif
        accelerate = 1'b0;
        pulses = 0;
        cyc(8);
        chk("t4_pulses", pulses, 4);

        // 5: set below MIN_CRUISE ignored; both pedals = no command
        brake = 1'b0;
        cyc(1);
        chk("t5_idle", int'(state), 0);
        speed = 7'd30;
        set_cruise = 1'b1;
        cyc(2);
        chk("t5_low_set", int'(state), 0);
        chk("t5_low_cruise", int'(cruise_on), 0);
        set_cruise = 1'b0;
        accelerate = 1'b1;
        decelerate = 1'b1;
        cyc(3);
        chk("t5_both", int'(state), 0);
        decelerate = 1'b0;

        // 6: reset mid-pulse clears outputs immediately
        speed = 7'd10;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc(1);
            seen = cnt_enable;
        end
        chk("t6_pulse_seen", int'(seen), 1);
        #1 clear = 1'b0;
        #1;
        chk("t6_rst_enable", int'(cnt_enable), 0);
        chk("t6_rst_mode", int'(cnt_mode), 0);
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_target", int'(target_speed), 0);
        accelerate = 1'b0;
        cyc(1);
        clear = 1'b1;
        cyc(1);

`ifdef CRUISE_RESUME_EN
        speed = 7'd60;
        set_cruise = 1'b1;
        cyc(1);
        set_cruise = 1'b0;
        cancel = 1'b1;
        cyc(1);
        chk("r_cancel_state", int'(state), 0);
        chk("r_kept_target", int'(target_speed), 60);
        cancel = 1'b0;
        resume = 1'b1;
        cyc(1);
        resume = 1'b0;
        chk("r_state", int'(state), 3);
        chk("r_target", int'(target_speed), 60);
        speed = 7'd58;
        follow = 1'b1;
        cyc(16);
        chk("r_converge", int'(speed), 60);
        follow = 1'b0;
`endif

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
